// File: rtl/spi_aes_frame_slave_pkg.sv
// Shared types and sizing for the SPI-to-AES frame slave.
// Holds the FSM state encoding, the AES block width and the frame width as a function of Nk.
package spi_aes_frame_slave_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    START,
    WAIT,
    SEND,
    HOLD
  } state_e;

  function automatic int frame_w(input int nk);
    return BLOCK_W + 32 * nk;
  endfunction

endpackage

// File: rtl/spi_aes_frame_slave_shifter.sv
// Generic MSB-first shift register with parallel load.
// Used once for the inbound data+key frame and once for the outbound result.
module aes_bit_shifter #(
  parameter int W = 128
) (
  input  logic         clk_master,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = load_val_i;
    end else if (shift_i) begin
      shift_d = {shift_q[W-2:0], bit_i};
    end
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q;

endmodule

// File: rtl/spi_aes_frame_slave.sv
// Serial frame slave: collects data+key MSB first, starts the AES core, then streams the
// 128-bit result back on sdo. Dropping cs at any point before HOLD abandons the frame.
module spi_aes_frame_slave
  import spi_aes_frame_slave_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic               clk_master,
  input  logic               rst,
  input  logic               cs,
  input  logic               sdi,
  output logic               sdo,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_data,
  output logic [Nk*32-1:0]   core_key,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               busy,
  output logic               frame_done
);

  localparam int FRAME_W = frame_w(Nk);
  localparam int KEY_W   = Nk * 32;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(BLOCK_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_done_q, frame_done_d;
  logic [BLOCK_W-1:0] core_data_q, core_data_d;
  logic [KEY_W-1:0]   core_key_q, core_key_d;

  logic               rx_shift, tx_load, tx_shift, core_load;
  logic [FRAME_W-1:0] rx_q;
  logic [BLOCK_W-1:0] tx_q;
  logic [FRAME_W-1:0] frame_rx;

  aes_bit_shifter #(.W(FRAME_W)) u_rx_shift (
    .clk_master (clk_master),
    .rst        (rst),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (rx_shift),
    .bit_i      (sdi),
    .q_o        (rx_q)
  );

  aes_bit_shifter #(.W(BLOCK_W)) u_tx_shift (
    .clk_master (clk_master),
    .rst        (rst),
    .load_i     (tx_load),
    .load_val_i (core_result),
    .shift_i    (tx_shift),
    .bit_i      (1'b0),
    .q_o        (tx_q)
  );

  // The core registers are loaded on the same edge that samples the last sdi bit,
  // so the complete frame is the shift register contents plus the incoming bit.
  assign frame_rx = {rx_q[FRAME_W-2:0], sdi};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    rx_shift     = 1'b0;
    tx_load      = 1'b0;
    tx_shift     = 1'b0;
    core_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs) begin
          state_d  = RECV;
          rx_shift = 1'b1;
          cnt_d    = CNT_W'(1);
        end
      end
      RECV: begin
        if (!cs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rx_shift = 1'b1;
          if (cnt_q == LAST_RX) begin
            state_d   = START;
            core_load = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = cs ? WAIT : IDLE;
      end
      WAIT: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (core_done) begin
          state_d = SEND;
          tx_load = 1'b1;
        end
      end
      SEND: begin
        if (!cs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          tx_shift = 1'b1;
          if (cnt_q == LAST_TX) begin
            state_d      = HOLD;
            cnt_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (!cs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    if (core_load) begin
      core_data_d = frame_rx[FRAME_W-1 -: BLOCK_W];
      core_key_d  = frame_rx[KEY_W-1:0];
    end
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      core_data_q  <= '0;
      core_key_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      core_data_q  <= core_data_d;
      core_key_q   <= core_key_d;
    end
  end

  assign sdo        = (state_q == SEND) & tx_q[BLOCK_W-1];
  assign core_start = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign core_data  = core_data_q;
  assign core_key   = core_key_q;

endmodule

// File: tb/tb_spi_aes_frame_slave.sv
// Self-checking bench for spi_aes_frame_slave with an Nk=4 and an Nk=8 instance.
// Expected values come from a frame-level model: slice the sent frame, serialise the core result.
module tb_spi_aes_frame_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel8;
  logic         cs_drv, sdi_drv, done_drv;
  logic [127:0] result_drv;

  logic         cs4, sdi4, done4, sdo4, start4, busy4, fdone4;
  logic [127:0] data4, key4;
  logic         cs8, sdi8, done8, sdo8, start8, busy8, fdone8;
  logic [127:0] data8;
  logic [255:0] key8;

  logic         sdo_s, start_s, busy_s, fdone_s;
  logic [127:0] data_s;
  logic [255:0] key_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign cs4   = sel8 ? 1'b0 : cs_drv;
  assign sdi4  = sel8 ? 1'b0 : sdi_drv;
  assign done4 = sel8 ? 1'b0 : done_drv;
  assign cs8   = sel8 ? cs_drv   : 1'b0;
  assign sdi8  = sel8 ? sdi_drv  : 1'b0;
  assign done8 = sel8 ? done_drv : 1'b0;

  assign sdo_s   = sel8 ? sdo8   : sdo4;
  assign start_s = sel8 ? start8 : start4;
  assign busy_s  = sel8 ? busy8  : busy4;
  assign fdone_s = sel8 ? fdone8 : fdone4;
  assign data_s  = sel8 ? data8  : data4;
  assign key_s   = sel8 ? key8   : {128'b0, key4};

  spi_aes_frame_slave #(.Nk(4), .Nr(10)) u_dut4 (
    .clk_master (clk),
    .rst        (rst),
    .cs         (cs4),
    .sdi        (sdi4),
    .sdo        (sdo4),
    .core_start (start4),
    .core_data  (data4),
    .core_key   (key4),
    .core_done  (done4),
    .core_result(result_drv),
    .busy       (busy4),
    .frame_done (fdone4)
  );

  spi_aes_frame_slave #(.Nk(8), .Nr(14)) u_dut8 (
    .clk_master (clk),
    .rst        (rst),
    .cs         (cs8),
    .sdi        (sdi8),
    .sdo        (sdo8),
    .core_start (start8),
    .core_data  (data8),
    .core_key   (key8),
    .core_done  (done8),
    .core_result(result_drv),
    .busy       (busy8),
    .frame_done (fdone8)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int j = 0; j < 12; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Shifts the first nbits of a total-bit frame in MSB first; nothing may start meanwhile.
  task automatic drive_frame(input logic [383:0] frame, input int total, input int nbits,
                             input bit spurious, input string name);
    int early;
    early = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (start_s !== 1'b0 || sdo_s !== 1'b0 || fdone_s !== 1'b0 || busy_s !== (i != 0)) early++;
      cs_drv   = 1'b1;
      sdi_drv  = frame[total-1-i];
      done_drv = spurious && (i == 50);
      if (spurious && i == 50) result_drv = rand128();
    end
    n_checks++;
    if (early != 0) begin
      n_errors++;
      $display("[TB] FAIL %s rx_phase: %0d bad cycles, expected 0", name, early);
    end
  endtask

  // Full transaction: frame in, core handshake after lat cycles, 128 result bits out, HOLD, release.
  task automatic run_frame(input bit nk8, input logic [383:0] frame, input logic [127:0] res,
                           input int lat, input int hold, input bit spurious, input int hold_cs,
                           input string name);
    int total, bad, fd;
    logic [127:0] exp_data, got;
    logic [255:0] exp_key;
    sel8     = nk8;
    total    = nk8 ? 384 : 256;
    exp_data = frame[total-1 -: 128];
    exp_key  = nk8 ? frame[255:0] : {128'b0, frame[127:0]};
    drive_frame(frame, total, total, spurious, name);
    done_drv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (start_s !== 1'b1 || busy_s !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL %s core_start: got start=%b busy=%b expected 1 1", name, start_s, busy_s);
    end
    n_checks++;
    if (data_s !== exp_data || key_s !== exp_key) begin
      n_errors++;
      $display("[TB] FAIL %s core_load: got data=%h key=%h expected data=%h key=%h",
               name, data_s, key_s, exp_data, exp_key);
    end
    sdi_drv = ($urandom % 2) == 1;
    bad = 0;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (start_s !== 1'b0 || sdo_s !== 1'b0 || busy_s !== 1'b1 || fdone_s !== 1'b0) bad++;
      if (c == lat - 1) begin
        done_drv   = 1'b1;
        result_drv = res;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("[TB] FAIL %s wait_phase: %0d bad cycles, expected 0", name, bad);
    end
    fd  = 0;
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      got[127-k] = sdo_s;
      if (busy_s !== 1'b1 || start_s !== 1'b0) bad++;
      if (fdone_s === 1'b1) fd++;
      done_drv = (k + 1 < hold);
      if (k + 1 < hold) result_drv = ~res;
    end
    n_checks++;
    if (got !== res) begin
      n_errors++;
      $display("[TB] FAIL %s sdo_stream: got %h expected %h", name, got, res);
    end
    n_checks++;
    if (fd != 0 || bad != 0) begin
      n_errors++;
      $display("[TB] FAIL %s send_phase: frame_done=%0d bad=%0d expected 0 0", name, fd, bad);
    end
    @(negedge clk);
    n_checks++;
    if (fdone_s !== 1'b1 || sdo_s !== 1'b0 || busy_s !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL %s frame_done: got fd=%b sdo=%b busy=%b expected 1 0 1",
               name, fdone_s, sdo_s, busy_s);
    end
    n_checks++;
    if (data_s !== exp_data || key_s !== exp_key) begin
      n_errors++;
      $display("[TB] FAIL %s core_stable: got data=%h expected %h", name, data_s, exp_data);
    end
    bad = 0;
    fd  = 0;
    for (int h = 0; h < hold_cs; h++) begin
      @(negedge clk);
      if (sdo_s !== 1'b0 || busy_s !== 1'b1) bad++;
      if (fdone_s === 1'b1) fd++;
    end
    n_checks++;
    if (bad != 0 || fd != 0) begin
      n_errors++;
      $display("[TB] FAIL %s hold_state: bad=%0d frame_done=%0d expected 0 0", name, bad, fd);
    end
    cs_drv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_s !== 1'b0 || sdo_s !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL %s release: got busy=%b sdo=%b expected 0 0", name, busy_s, sdo_s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sdo4, start4, busy4, fdone4, data4, key4} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_nk4: got sdo=%b start=%b busy=%b fd=%b data=%h expected all 0",
               sdo4, start4, busy4, fdone4, data4);
    end
    n_checks++;
    if ({sdo8, start8, busy8, fdone8, data8, key8} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_nk8: got sdo=%b start=%b busy=%b fd=%b data=%h expected all 0",
               sdo8, start8, busy8, fdone8, data8);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [383:0] frame;
    frame = '0;
    frame[255:0] = {128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f};
    run_frame(1'b0, frame, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 12, 1, 1'b0, 4, "nominal");
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 3; n++) begin
      run_frame(1'b0, rand384(), rand128(), $urandom_range(1, 20), $urandom_range(1, 3),
                1'b0, $urandom_range(0, 5), "random_nk4");
    end
  endtask

  task automatic test_nk8();
    run_frame(1'b1, rand384(), rand128(), $urandom_range(1, 15), 1, 1'b0, 2, "nk8");
  endtask

  task automatic test_abort_recv();
    int bad;
    sel8 = 1'b0;
    drive_frame(rand384(), 256, 100, 1'b0, "abort_recv");
    @(negedge clk);
    cs_drv = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy_s !== 1'b0 || start_s !== 1'b0 || sdo_s !== 1'b0 || fdone_s !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("[TB] FAIL abort_recv_idle: %0d bad cycles, expected 0", bad);
    end
    run_frame(1'b0, rand384(), rand128(), 5, 1, 1'b0, 1, "after_abort_recv");
  endtask

  task automatic test_abort_wait();
    int bad;
    sel8 = 1'b0;
    drive_frame(rand384(), 256, 256, 1'b0, "abort_wait");
    @(negedge clk);
    n_checks++;
    if (start_s !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL abort_wait_start: got %b expected 1", start_s);
    end
    @(negedge clk);
    cs_drv = 1'b0;
    @(negedge clk);
    done_drv   = 1'b1;
    result_drv = rand128();
    bad = (busy_s !== 1'b0) ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      done_drv = 1'b0;
      if (busy_s !== 1'b0 || sdo_s !== 1'b0 || fdone_s !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("[TB] FAIL abort_wait_drop: %0d bad cycles, expected 0", bad);
    end
    run_frame(1'b0, rand384(), rand128(), 3, 2, 1'b0, 1, "after_abort_wait");
  endtask

  task automatic test_reset_in_send();
    logic [383:0] frame;
    logic [127:0] res;
    logic [39:0]  got;
    int fd;
    sel8  = 1'b0;
    frame = rand384();
    res   = rand128();
    drive_frame(frame, 256, 256, 1'b0, "reset_in_send");
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        done_drv   = 1'b1;
        result_drv = res;
      end
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      done_drv   = 1'b0;
      got[39-k]  = sdo_s;
    end
    n_checks++;
    if (got !== res[127:88]) begin
      n_errors++;
      $display("[TB] FAIL reset_in_send_bits: got %h expected %h", got, res[127:88]);
    end
    #1;
    rst    = 1'b1;
    cs_drv = 1'b0;
    #1;
    n_checks++;
    if ({sdo_s, start_s, busy_s, fdone_s, data_s, key_s} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_in_send_outputs: got sdo=%b start=%b busy=%b fd=%b data=%h expected all 0",
               sdo_s, start_s, busy_s, fdone_s, data_s);
    end
    fd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (fdone_s !== 1'b0) fd++;
    end
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (fdone_s !== 1'b0 || busy_s !== 1'b0) fd++;
    end
    n_checks++;
    if (fd != 0) begin
      n_errors++;
      $display("[TB] FAIL reset_in_send_quiet: %0d bad cycles, expected 0", fd);
    end
    run_frame(1'b0, rand384(), rand128(), 4, 1, 1'b0, 1, "after_reset");
  endtask

  task automatic test_spurious_done();
    run_frame(1'b0, rand384(), rand128(), 6, 5, 1'b1, 3, "spurious_done");
  endtask

  initial begin
    rst        = 1'b1;
    sel8       = 1'b0;
    cs_drv     = 1'b0;
    sdi_drv    = 1'b0;
    done_drv   = 1'b0;
    result_drv = '0;
    test_reset();
    test_nominal();
    test_random_frames();
    test_nk8();
    test_abort_recv();
    test_abort_wait();
    test_reset_in_send();
    test_spurious_done();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_aes_frame_slave.md
SPI_AES_FRAME_SLAVE -- requirements
Module: spi_aes_frame_slave

Interface
REQ-001 SHALL have parameter Nk, default 4, meaning key length in 32-bit words (legal values 4, 6, 8).
REQ-002 SHALL have parameter Nr, default 10, meaning round count; pass-through only, not used internally.
REQ-003 SHALL have port clk_master, input, 1, system clock; all logic SHALL be clocked on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port cs, input, 1, frame select (active-high).
REQ-006 SHALL have port sdi, input, 1, serial data from the master.
REQ-007 SHALL have port sdo, output, 1, serial result to the master.
REQ-008 SHALL have port core_start, output, 1, one-cycle start pulse to the AES core.
REQ-009 SHALL have port core_data, output, 128, plaintext/ciphertext block presented to the core.
REQ-010 SHALL have port core_key, output, Nk*32, key presented to the core.
REQ-011 SHALL have port core_done, input, 1, core result valid (pulse or level).
REQ-012 SHALL have port core_result, input, 128, core output block.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse after the last sdo bit is driven.

Function
REQ-015 FRAME_W SHALL equal 128+32*Nk; the inbound frame SHALL be data[127] first, down to key[0] last (MSB first).
REQ-016 The FSM SHALL have states IDLE, RECV, START, WAIT, SEND and HOLD.
REQ-017 IDLE->RECV SHALL occur on the first rising edge with cs=1; sdi SHALL be sampled on that same edge as bit FRAME_W-1.
REQ-018 RECV SHALL shift one sdi bit per cycle into a FRAME_W shift register and count bits 0..FRAME_W-1.
REQ-019 After bit FRAME_W bits are received, RECV->START SHALL occur; core_data and core_key SHALL be loaded from the shift register.
REQ-020 START SHALL assert core_start for exactly one cycle, then go to WAIT.
REQ-021 core_data and core_key SHALL remain stable from START until the FSM returns to IDLE.
REQ-022 WAIT SHALL capture core_result on the first cycle with core_done=1, then go to SEND.
REQ-023 A core_done asserted in any state other than WAIT SHALL be ignored.
REQ-024 SEND SHALL drive sdo from the captured result, bit 127 first, updating on each rising edge, for exactly 128 cycles.
REQ-025 After the 128th bit, SEND->HOLD SHALL occur and frame_done SHALL pulse for one cycle.
REQ-026 HOLD SHALL wait for cs=0, then go to IDLE; this forbids back-to-back frames without a cs gap.
REQ-027 In any state other than SEND, sdo SHALL be 0.
REQ-028 cs=0 in RECV, START, WAIT or SEND SHALL abort to IDLE on the next edge, clear counters, and emit no frame_done.
REQ-029 If core_start is already issued before an abort, a later core_done SHALL be dropped.
REQ-030 Latency SHALL be: core_start one cycle after the last sdi bit; first sdo bit one cycle after core_done is sampled.

Reset
REQ-031 On rst=1, the block SHALL asynchronously enter IDLE.
REQ-032 On rst=1, sdo, core_start, busy and frame_done SHALL be 0.
REQ-033 On rst=1, core_data, core_key, the shift register, the captured result and the bit counter SHALL be 0.
REQ-034 rst mid-frame SHALL discard all partial data; the next frame SHALL start cleanly from IDLE.

Structure
REQ-035 The shared package SHALL hold the state encoding, the BLOCK_W=128 constant and the FRAME_W function of Nk.
REQ-036 A single sub-module, aes_bit_shifter (parameterised width, load/shift-in/shift-out MSB first), SHALL be instantiated twice: once inbound and once outbound.
REQ-037 The bit counter SHALL be sized to clog2(FRAME_W).

Verification
REQ-038 Nominal: Nk=4, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 12 cycles -> core_start one cycle after bit 256; sdo serialises 69c4… MSB first; frame_done pulses once.
REQ-039 Nk=8 variant -> 384-bit frame; core_key equals the sent 256-bit key; core_start fires after bit 384, not 256.
REQ-040 cs dropped after 100 bits -> IDLE, no core_start; the next full frame is processed correctly.
REQ-041 rst asserted in SEND after 40 result bits -> all outputs 0 immediately; no frame_done is emitted.
REQ-042 A spurious core_done during RECV and a core_done held high for 5 cycles in WAIT -> a single capture only; sdo matches the first result.
REQ-043 cs held high after frame_done -> the FSM stays in HOLD with sdo=0 until cs falls.
